mem8_burst_reader: RTL

MEM8_BURST_READER -- requirements
Module: mem8_burst_reader

---
 rtl/mem8_pkg.sv | 18 +
 rtl/dff_byte.sv | 19 +
 rtl/mem8_burst_reader.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem8_pkg.sv
// Shared widths, the FSM state type and the pointer-advance helper for the
// mem8 burst reader.
package mem8_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  // Natural 3-bit overflow gives the 7 -> 0 wrap.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return a + 1'b1;
  endfunction
endpackage

// File: rtl/dff_byte.sv
// One storage byte: enabled D register with async active-low clear.
import mem8_pkg::*;

module dff_byte (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_q <= '0;
    else if (i_en) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/mem8_burst_reader.sv
// 8-byte register file with a ready/valid burst read port. The next beat is
// fetched at the transfer edge, so rd_data is a pure register (no ready path).
import mem8_pkg::*;

module mem8_burst_reader (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] burst_len,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              done
);
  logic [DEPTH-1:0][DATA_W-1:0] w_mem;
  logic [DEPTH-1:0]             w_we;
  logic [ADDR_W-1:0]            w_nxt;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic              r_busy;
  logic              r_done;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_mem
      assign w_we[g] = wr_en && (wr_addr == ADDR_W'(g));
      dff_byte u_byte (
        .clk  (clk),
        .rst_n(reset),
        .i_en (w_we[g]),
        .i_d  (wr_data),
        .o_q  (w_mem[g])
      );
    end
  endgenerate

  assign w_nxt = next_addr(r_ptr);

  // Reads sample the storage registers before this edge's write lands,
  // which is what gives old-data behaviour on a same-edge collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ptr      <= start_addr;
            r_rem      <= burst_len;
            r_rd_data  <= w_mem[start_addr];
            r_rd_valid <= 1'b1;
            r_rd_last  <= (burst_len == '0);
            r_busy     <= 1'b1;
            r_state    <= READ;
          end
        end
        READ: begin
          if (rd_ready) begin
            if (r_rem == '0) begin
              r_rd_valid <= 1'b0;
              r_rd_last  <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_ptr     <= w_nxt;
              r_rem     <= r_rem - 1'b1;
              r_rd_data <= w_mem[w_nxt];
              r_rd_last <= (r_rem == ADDR_W'(1));
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_rd_valid <= 1'b0;
          r_rd_last  <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign busy     = r_busy;
  assign done     = r_done;
endmodule
